// File: rtl/alu_mul_seq.sv
// alu_mul_seq - multi-cycle shift-add multiply sequencer.
//
// Computes the low WIDTH bits of i_multiplicand * i_multiplier by driving
// the shared datapath ALU with one ADD per iteration. It stops as soon as
// the remaining multiplier bits are all zero, so a multiply takes
// (index of highest set multiplier bit)+1 RUN cycles, with a minimum of one.
//
// Ports:
//   i_clk          rising-edge clock
//   i_reset        asynchronous, active-high reset
//   i_start        operation request, sampled only while idle
//   i_multiplicand operand A, latched on an accepted start
//   i_multiplier   operand B, latched on an accepted start
//   o_busy         high while iterating
//   o_done         one-cycle pulse, o_product valid
//   o_product      low WIDTH bits of the product, held until the next start
//   o_alu_a        ALU operand a (accumulator while iterating, else 0)
//   o_alu_b        ALU operand b (shifted multiplicand or 0)
//   o_alu_control  ALU control, always ADD_CTRL
//   i_alu_result   combinational ALU result for the current o_alu_* values
module alu_mul_seq #(
  parameter int          WIDTH    = 64,
  parameter logic [3:0]  ADD_CTRL = 4'b0010
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_multiplicand,
  input  logic [WIDTH-1:0] i_multiplier,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_product,
  output logic [WIDTH-1:0] o_alu_a,
  output logic [WIDTH-1:0] o_alu_b,
  output logic [3:0]       o_alu_control,
  input  logic [WIDTH-1:0] i_alu_result
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // Iteration index of the last possible step (all WIDTH multiplier bits).
  localparam logic [5:0] CNT_LAST = 6'(WIDTH - 1);

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0] r_mplier;
  logic [5:0]       r_cnt;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_product;
  logic [WIDTH-1:0] r_alu_a;
  logic [WIDTH-1:0] r_alu_b;
  logic [3:0]       r_alu_control;

  logic [1:0]       w_state_nxt;
  logic [WIDTH-1:0] w_acc_nxt;
  logic [WIDTH-1:0] w_mcand_nxt;
  logic [WIDTH-1:0] w_mplier_nxt;
  logic [5:0]       w_cnt_nxt;
  logic [WIDTH-1:0] w_product_nxt;
  logic [WIDTH-1:0] w_alu_a_nxt;
  logic [WIDTH-1:0] w_alu_b_nxt;

  // Next-state and datapath update for the IDLE/RUN/DONE sequencer.
  always_comb begin
    w_state_nxt  = r_state;
    w_acc_nxt    = r_acc;
    w_mcand_nxt  = r_mcand;
    w_mplier_nxt = r_mplier;
    w_cnt_nxt    = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_state_nxt  = S_RUN;
          w_acc_nxt    = {WIDTH{1'b0}};
          w_mcand_nxt  = i_multiplicand;
          w_mplier_nxt = i_multiplier;
          w_cnt_nxt    = 6'd0;
        end else begin
          w_state_nxt  = S_IDLE;
        end
      end
      S_RUN: begin
        w_acc_nxt    = i_alu_result;
        w_mcand_nxt  = r_mcand << 1;
        w_mplier_nxt = r_mplier >> 1;
        w_cnt_nxt    = r_cnt + 6'd1;
        // Early exit: no multiplier bits left after this step's shift.
        if ((r_cnt == CNT_LAST) || (w_mplier_nxt == {WIDTH{1'b0}})) begin
          w_state_nxt = S_DONE;
        end else begin
          w_state_nxt = S_RUN;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Registered output values derived from the next state, so the ALU
  // operands track the accumulator/multiplicand seen in the coming cycle.
  always_comb begin
    w_product_nxt = r_product;
    w_alu_a_nxt   = {WIDTH{1'b0}};
    w_alu_b_nxt   = {WIDTH{1'b0}};
    if (w_state_nxt == S_RUN) begin
      w_alu_a_nxt = w_acc_nxt;
      if (w_mplier_nxt[0]) begin
        w_alu_b_nxt = w_mcand_nxt;
      end else begin
        w_alu_b_nxt = {WIDTH{1'b0}};
      end
    end else if (w_state_nxt == S_DONE) begin
      w_product_nxt = w_acc_nxt;
    end else begin
      w_alu_a_nxt = {WIDTH{1'b0}};
    end
  end

  // State, datapath and output registers.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state       <= S_IDLE;
      r_acc         <= {WIDTH{1'b0}};
      r_mcand       <= {WIDTH{1'b0}};
      r_mplier      <= {WIDTH{1'b0}};
      r_cnt         <= 6'd0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_product     <= {WIDTH{1'b0}};
      r_alu_a       <= {WIDTH{1'b0}};
      r_alu_b       <= {WIDTH{1'b0}};
      r_alu_control <= ADD_CTRL;
    end else begin
      r_state       <= w_state_nxt;
      r_acc         <= w_acc_nxt;
      r_mcand       <= w_mcand_nxt;
      r_mplier      <= w_mplier_nxt;
      r_cnt         <= w_cnt_nxt;
      r_busy        <= (w_state_nxt == S_RUN);
      r_done        <= (w_state_nxt == S_DONE);
      r_product     <= w_product_nxt;
      r_alu_a       <= w_alu_a_nxt;
      r_alu_b       <= w_alu_b_nxt;
      r_alu_control <= ADD_CTRL;
    end
  end

  assign o_busy        = r_busy;
  assign o_done        = r_done;
  assign o_product     = r_product;
  assign o_alu_a       = r_alu_a;
  assign o_alu_b       = r_alu_b;
  assign o_alu_control = r_alu_control;

endmodule

// File: tb/tb_alu_mul_seq.sv
// Testbench for alu_mul_seq: directed corner cases plus randomized operands,
// checked against a reference that computes the product with '*' and the
// expected RUN length from the highest set multiplier bit.
module tb_alu_mul_seq;

  localparam logic [3:0] ADD = 4'b0010;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [63:0] mcand_in;
  logic [63:0] mplier_in;
  logic        busy;
  logic        done;
  logic [63:0] product;
  logic [63:0] alu_a;
  logic [63:0] alu_b;
  logic [3:0]  alu_control;
  logic [63:0] alu_result;

  int n_err = 0;
  int n_chk = 0;
  bit mon_en = 1'b0;

  always #5 clk = ~clk;

  // Behavioural ALU: only ADD is needed by the sequencer.
  assign alu_result = (alu_control == ADD) ? (alu_a + alu_b) : 64'h0;

  alu_mul_seq dut (
    .i_clk          (clk),
    .i_reset        (reset),
    .i_start        (start),
    .i_multiplicand (mcand_in),
    .i_multiplier   (mplier_in),
    .o_busy         (busy),
    .o_done         (done),
    .o_product      (product),
    .o_alu_a        (alu_a),
    .o_alu_b        (alu_b),
    .o_alu_control  (alu_control),
    .i_alu_result   (alu_result)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Reference RUN length: highest set multiplier bit index + 1, minimum 1.
  function automatic int exp_n(input logic [63:0] b);
    int n;
    n = 1;
    for (int i = 0; i < 64; i++) begin
      if (b[i]) n = i + 1;
    end
    return n;
  endfunction

  // busy and done must never be high together.
  always @(negedge clk) begin
    if (mon_en) check("busy_done_overlap", {63'd0, busy & done}, 64'd0);
  end

  task automatic run_op(input logic [63:0] a, input logic [63:0] b, input bit glitch);
    int          cyc;
    int          n_ref;
    logic [63:0] p_ref;
    p_ref = a * b;
    n_ref = exp_n(b);
    @(negedge clk);
    start = 1'b1; mcand_in = a; mplier_in = b;
    @(posedge clk); #1;
    start = 1'b0;
    mcand_in = {$urandom(), $urandom()};
    mplier_in = {$urandom(), $urandom()};
    cyc = 0;
    while (busy && cyc < 100) begin
      if (cyc == 0) check("alu_ctrl_run", {60'd0, alu_control}, {60'd0, ADD});
      if (glitch && cyc == 2) begin
        start = 1'b1;
        mcand_in = {$urandom(), $urandom()};
        mplier_in = {$urandom(), $urandom()} | 64'h1;
      end else begin
        start = 1'b0;
      end
      cyc++;
      @(posedge clk); #1;
    end
    start = 1'b0;
    check("run_cycles", 64'(cyc), 64'(n_ref));
    check("done_high", {63'd0, done}, 64'd1);
    check("product", product, p_ref);
    @(posedge clk); #1;
    check("done_pulse_len", {63'd0, done}, 64'd0);
    check("product_hold", product, p_ref);
    check("idle_alu_a", alu_a, 64'd0);
    check("idle_alu_b", alu_b, 64'd0);
  endtask

  initial begin
    logic [63:0] ra;
    logic [63:0] rb;
    logic        seen;
    reset = 1'b1; start = 1'b0; mcand_in = 64'd0; mplier_in = 64'd0;
    #12;
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_product", product, 64'd0);
    check("rst_alu_ctrl", {60'd0, alu_control}, {60'd0, ADD});
    @(negedge clk); reset = 1'b0; mon_en = 1'b1;
    seen = 1'b0;
    repeat (4) begin @(posedge clk); #1; seen = seen | done | busy; end
    check("idle_no_activity", {63'd0, seen}, 64'd0);

    // Directed corner cases.
    run_op(64'd3, 64'd5, 1'b0);
    run_op(64'h1234, 64'd0, 1'b0);
    run_op(64'hDEAD, 64'd1, 1'b0);
    run_op(64'hFFFF_FFFF_FFFF_FFFD, 64'd7, 1'b0);
    run_op(64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0);
    run_op(64'h1_0000_0000, 64'h1_0000_0000, 1'b0);
    run_op(64'd1, 64'h8000_0000_0000_0000, 1'b0);
    check("signed_const", 64'hFFFF_FFFF_FFFF_FFFD * 64'd7, 64'hFFFF_FFFF_FFFF_FFEB);

    // Small operand sweep.
    for (int i = 0; i < 10; i++) begin
      for (int j = 0; j < 10; j++) begin
        run_op(64'(i), 64'(j), 1'b0);
      end
    end

    // Start pulses during RUN must be ignored.
    run_op(64'd3, 64'h80, 1'b1);
    for (int k = 0; k < 4; k++) begin
      ra = {$urandom(), $urandom()};
      rb = {$urandom(), $urandom()} | 64'h8000_0000_0000_0000;
      run_op(ra, rb, 1'b1);
    end

    // Randomized operands with varied multiplier length.
    for (int k = 0; k < 40; k++) begin
      ra = {$urandom(), $urandom()};
      rb = {$urandom(), $urandom()};
      rb = rb >> $urandom_range(63, 0);
      run_op(ra, rb, 1'b0);
    end

    // Asynchronous reset in the middle of RUN.
    run_op(64'h1234_5678, 64'd9, 1'b0);
    @(negedge clk);
    start = 1'b1; mcand_in = 64'h55; mplier_in = 64'h8000_0000_0000_0001;
    @(posedge clk); #1; start = 1'b0;
    repeat (5) @(posedge clk);
    #3; reset = 1'b1; #1;
    check("midrun_rst_busy", {63'd0, busy}, 64'd0);
    check("midrun_rst_done", {63'd0, done}, 64'd0);
    check("midrun_rst_product", product, 64'd0);
    check("midrun_rst_alu_a", alu_a, 64'd0);
    check("midrun_rst_alu_b", alu_b, 64'd0);
    check("midrun_rst_alu_ctrl", {60'd0, alu_control}, {60'd0, ADD});
    @(negedge clk); reset = 1'b0;
    seen = 1'b0;
    repeat (70) begin @(posedge clk); #1; seen = seen | done; end
    check("no_done_after_rst", {63'd0, seen}, 64'd0);
    run_op(64'd3, 64'd5, 1'b0);

    mon_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
